// File: rtl/read_burst_pkg.sv
// Shared state encoding and byte/strobe helpers for read_burst_realigner.
package read_burst_pkg;

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM, S_FLUSH} state_t;

    localparam int unsigned MAX_BYTES = 64;

    function automatic int unsigned bytes_of(input int unsigned width);
        return width / 8;
    endfunction

    // Low (rem mod nbytes) strobes set; a whole-beat tail keeps every byte.
    function automatic logic [MAX_BYTES-1:0] tail_strb(input int unsigned rem,
                                                       input int unsigned nbytes);
        int unsigned r;
        r = rem % nbytes;
        if (r == 0) return '1;
        return (MAX_BYTES'(1) << r) - MAX_BYTES'(1);
    endfunction

endpackage

// File: rtl/byte_merge_shifter.sv
// Combinational byte funnel: low DATA_WIDTH bits of {hi, lo} >> shamt bytes.
module byte_merge_shifter #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0]           hi,
    input  logic [DATA_WIDTH-1:0]           lo,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] shamt,
    output logic [DATA_WIDTH-1:0]           merged
);

    always_comb begin
        merged = DATA_WIDTH'({hi, lo} >> {shamt, 3'b000});
    end

endmodule

// File: rtl/read_burst_realigner.sv
// Repacks an offset read burst to byte 0 and trims it to an exact byte length.
// Define READ_BURST_REALIGNER_STRB_EN for the o_strb port and tail-byte zeroing.
module read_burst_realigner
    import read_burst_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_valid,
    output logic                            i_ready,
    input  logic                            i_start,
    input  logic                            i_end,
    input  logic [DATA_WIDTH-1:0]           i_data,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] i_shamt,
    input  logic [LEN_WIDTH-1:0]            i_len,
    output logic                            o_valid,
    input  logic                            o_ready,
    output logic                            o_start,
    output logic                            o_end,
    output logic [DATA_WIDTH-1:0]           o_data,
`ifdef READ_BURST_REALIGNER_STRB_EN
    output logic [DATA_WIDTH/8-1:0]         o_strb,
`endif
    output logic                            o_idle
);

    localparam int unsigned          B     = bytes_of(DATA_WIDTH);
    localparam int unsigned          SW    = $clog2(B);
    localparam logic [LEN_WIDTH-1:0] B_LEN = LEN_WIDTH'(B);

    state_t                state;
    logic [DATA_WIDTH-1:0] prev;
    logic [SW-1:0]         shamt_r;
    logic [LEN_WIDTH-1:0]  rem;
    logic                  first_r;

    logic                  out_free;
    logic                  accept;
    logic                  is_start;
    logic [LEN_WIDTH-1:0]  eff_rem;
    logic [SW-1:0]         eff_shamt;
    logic                  emit_in;
    logic                  emit_flush;
    logic [DATA_WIDTH-1:0] sh_hi;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] beat_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  beat_end;
    logic [LEN_WIDTH-1:0]  rem_next;
`ifdef READ_BURST_REALIGNER_STRB_EN
    logic [B-1:0]          beat_strb;
`endif

    // One shifter serves both paths: the flush beat merges zeros above the held beat.
    byte_merge_shifter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_shifter (
        .hi    (sh_hi),
        .lo    (prev),
        .shamt (shamt_r),
        .merged(merged)
    );

    always_comb begin
        out_free   = !o_valid || o_ready;
        i_ready    = (state != S_FLUSH) && out_free;
        o_idle     = (state == S_IDLE) && !o_valid;
        accept     = i_valid && i_ready;
        is_start   = accept && i_start;
        eff_rem    = is_start ? i_len : rem;
        eff_shamt  = is_start ? i_shamt : shamt_r;
        emit_flush = (state == S_FLUSH) && out_free && (rem != '0);
        emit_in    = accept && (eff_rem != '0) &&
                     (is_start ? (i_shamt == '0) : (state == S_PRIME || state == S_STREAM));
        sh_hi      = (state == S_FLUSH) ? '0 : i_data;
        beat_data  = ((state != S_FLUSH) && (eff_shamt == '0)) ? i_data : merged;
        beat_end   = (state == S_FLUSH) || (eff_rem <= B_LEN);
        rem_next   = (eff_rem > B_LEN) ? eff_rem - B_LEN : '0;
        out_data   = beat_data;
`ifdef READ_BURST_REALIGNER_STRB_EN
        beat_strb  = beat_end ? B'(tail_strb(32'(eff_rem), B)) : '1;
        for (int unsigned i = 0; i < B; i++) begin
            if (!beat_strb[i]) out_data[i*8 +: 8] = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            prev    <= '0;
            shamt_r <= '0;
            rem     <= '0;
            first_r <= 1'b0;
            o_valid <= 1'b0;
            o_start <= 1'b0;
            o_end   <= 1'b0;
            o_data  <= '0;
`ifdef READ_BURST_REALIGNER_STRB_EN
            o_strb  <= '0;
`endif
        end else begin
            if (emit_in || emit_flush) begin
                o_valid <= 1'b1;
                o_start <= is_start || first_r;
                o_end   <= beat_end;
                o_data  <= out_data;
`ifdef READ_BURST_REALIGNER_STRB_EN
                o_strb  <= beat_strb;
`endif
                first_r <= 1'b0;
            end else begin
                if (o_ready) o_valid <= 1'b0;
                if (is_start) first_r <= 1'b1;
            end

            if (accept) begin
                prev <= i_data;
                if (is_start) begin
                    // A start beat in any state restarts the burst; held output is untouched.
                    shamt_r <= i_shamt;
                    rem     <= emit_in ? rem_next : i_len;
                    if (i_end)
                        state <= ((i_shamt != '0) && (i_len != '0)) ? S_FLUSH : S_IDLE;
                    else
                        state <= (i_shamt != '0) ? S_PRIME : S_STREAM;
                end else if (state != S_IDLE) begin
                    if (emit_in) rem <= rem_next;
                    if (i_end)
                        state <= (emit_in && (shamt_r != '0) && (rem_next != '0)) ? S_FLUSH : S_IDLE;
                    else
                        state <= S_STREAM;
                end
            end else if ((state == S_FLUSH) && out_free) begin
                rem   <= '0;
                state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_read_burst_realigner.sv
// Directed, table-driven bench for read_burst_realigner (B=8), plus backpressure and reset sequences.
module tb_read_burst_realigner;

    localparam logic [63:0] D0 = 64'h0706050403020100;
    localparam logic [63:0] D1 = 64'h0F0E0D0C0B0A0908;
    localparam logic [63:0] D2 = 64'h1716151413121110;
    localparam int unsigned NV = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_ready, i_start, i_end;
    logic [63:0] i_data;
    logic [2:0]  i_shamt;
    logic [15:0] i_len;
    logic        o_valid, o_ready, o_start, o_end, o_idle;
    logic [63:0] o_data;
`ifdef READ_BURST_REALIGNER_STRB_EN
    logic [7:0]  o_strb;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        vld, st, en;
        logic [63:0] data;
        logic [2:0]  sh;
        logic [15:0] len;
        logic        e_vld, e_st, e_en;
        logic [63:0] e_data;
        logic [7:0]  e_strb;
    } vec_t;

    vec_t vecs[NV];

    read_burst_realigner #(
        .DATA_WIDTH(64),
        .LEN_WIDTH (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_valid(i_valid),
        .i_ready(i_ready),
        .i_start(i_start),
        .i_end  (i_end),
        .i_data (i_data),
        .i_shamt(i_shamt),
        .i_len  (i_len),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .o_start(o_start),
        .o_end  (o_end),
        .o_data (o_data),
`ifdef READ_BURST_REALIGNER_STRB_EN
        .o_strb (o_strb),
`endif
        .o_idle (o_idle)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic vld, input logic st, input logic en,
                                input logic [63:0] d, input logic [2:0] sh, input logic [15:0] len,
                                input logic ev, input logic es, input logic ee,
                                input logic [63:0] ed, input logic [7:0] eb);
        vec_t v;
        v.vld = vld; v.st = st; v.en = en; v.data = d; v.sh = sh; v.len = len;
        v.e_vld = ev; v.e_st = es; v.e_en = ee; v.e_data = ed; v.e_strb = eb;
        return v;
    endfunction

`ifdef READ_BURST_REALIGNER_STRB_EN
    function automatic logic [63:0] expand(input logic [7:0] s);
        logic [63:0] m;
        for (int unsigned i = 0; i < 8; i++) m[i*8 +: 8] = s[i] ? 8'hFF : 8'h00;
        return m;
    endfunction
`endif

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic st, input logic en,
                         input logic [63:0] d, input logic [2:0] sh, input logic [15:0] len);
        i_valid = vld; i_start = st; i_end = en; i_data = d; i_shamt = sh; i_len = len;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] exp_d;

        // Expected output is the registered beat after each vector's clock edge (o_ready=1).
        vecs[0]  = mk(1'b1, 1'b1, 1'b0, D0, 3'd0, 16'd24, 1'b1, 1'b1, 1'b0, D0, 8'hFF);
        vecs[1]  = mk(1'b1, 1'b0, 1'b0, D1, 3'd0, 16'd0,  1'b1, 1'b0, 1'b0, D1, 8'hFF);
        vecs[2]  = mk(1'b1, 1'b0, 1'b1, D2, 3'd0, 16'd0,  1'b1, 1'b0, 1'b1, D2, 8'hFF);
        vecs[3]  = mk(1'b1, 1'b1, 1'b0, D0, 3'd3, 16'd16, 1'b0, 1'b0, 1'b0, 64'h0, 8'h00);
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, D1, 3'd0, 16'd0,  1'b1, 1'b1, 1'b0, 64'h0A09080706050403, 8'hFF);
        vecs[5]  = mk(1'b1, 1'b0, 1'b1, D2, 3'd0, 16'd0,  1'b1, 1'b0, 1'b1, 64'h1211100F0E0D0C0B, 8'hFF);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, D0, 3'd0, 16'd0,  1'b0, 1'b0, 1'b0, 64'h0, 8'h00);
        vecs[7]  = mk(1'b1, 1'b1, 1'b0, D0, 3'd4, 16'd12, 1'b0, 1'b0, 1'b0, 64'h0, 8'h00);
        vecs[8]  = mk(1'b1, 1'b0, 1'b1, D1, 3'd0, 16'd0,  1'b1, 1'b1, 1'b0, 64'h0B0A090807060504, 8'hFF);
        vecs[9]  = mk(1'b0, 1'b0, 1'b0, D0, 3'd0, 16'd0,  1'b1, 1'b0, 1'b1, 64'h000000000F0E0D0C, 8'h0F);
        vecs[10] = mk(1'b1, 1'b1, 1'b1, D0, 3'd2, 16'd4,  1'b0, 1'b0, 1'b0, 64'h0, 8'h00);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, D0, 3'd0, 16'd0,  1'b1, 1'b1, 1'b1, 64'h0000070605040302, 8'h0F);
        vecs[12] = mk(1'b1, 1'b1, 1'b1, D2, 3'd0, 16'd0,  1'b0, 1'b0, 1'b0, 64'h0, 8'h00);
        vecs[13] = mk(1'b0, 1'b0, 1'b0, D0, 3'd0, 16'd0,  1'b0, 1'b0, 1'b0, 64'h0, 8'h00);
        vecs[14] = mk(1'b1, 1'b1, 1'b1, D1, 3'd0, 16'd5,  1'b1, 1'b1, 1'b1, D1, 8'h1F);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, D0, 3'd0, 16'd0,  1'b0, 1'b0, 1'b0, 64'h0, 8'h00);
        vecs[16] = mk(1'b1, 1'b1, 1'b0, D0, 3'd0, 16'd24, 1'b1, 1'b1, 1'b0, D0, 8'hFF);
        vecs[17] = mk(1'b1, 1'b1, 1'b0, D2, 3'd1, 16'd8,  1'b0, 1'b0, 1'b0, 64'h0, 8'h00);
        vecs[18] = mk(1'b1, 1'b0, 1'b1, D0, 3'd0, 16'd0,  1'b1, 1'b1, 1'b1, 64'h0017161514131211, 8'hFF);
        vecs[19] = mk(1'b0, 1'b0, 1'b0, D0, 3'd0, 16'd0,  1'b0, 1'b0, 1'b0, 64'h0, 8'h00);

        rst = 1'b1;
        o_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 64'h0, 3'd0, 16'd0);
        #2;
        check_bit("reset o_valid", o_valid, 1'b0);
        check_bit("reset o_idle", o_idle, 1'b1);
        check_bit("reset i_ready", i_ready, 1'b1);
        check_bit("reset o_start", o_start, 1'b0);
        check_bit("reset o_end", o_end, 1'b0);
        check_word("reset o_data", o_data, 64'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int k = 0; k < NV; k++) begin
            drive(vecs[k].vld, vecs[k].st, vecs[k].en, vecs[k].data, vecs[k].sh, vecs[k].len);
            tick();
            check_bit($sformatf("vec%0d o_valid", k), o_valid, vecs[k].e_vld);
            if (vecs[k].e_vld) begin
                check_bit($sformatf("vec%0d o_start", k), o_start, vecs[k].e_st);
                check_bit($sformatf("vec%0d o_end", k), o_end, vecs[k].e_en);
                exp_d = vecs[k].e_data;
`ifdef READ_BURST_REALIGNER_STRB_EN
                exp_d = exp_d & expand(vecs[k].e_strb);
                check_word($sformatf("vec%0d o_strb", k), 64'(o_strb), 64'(vecs[k].e_strb));
`endif
                check_word($sformatf("vec%0d o_data", k), o_data, exp_d);
            end
        end

        // Output stall mid-burst: input must be held off and the held beat must not change.
        drive(1'b1, 1'b1, 1'b0, D0, 3'd0, 16'd32);
        tick();
        check_word("bp beat0 data", o_data, D0);
        check_bit("bp beat0 start", o_start, 1'b1);
        drive(1'b1, 1'b0, 1'b0, D1, 3'd0, 16'd0);
        tick();
        check_word("bp beat1 data", o_data, D1);
        o_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, D2, 3'd0, 16'd0);
        for (int unsigned c = 0; c < 3; c++) begin
            #1;
            check_bit($sformatf("bp stall%0d i_ready", c), i_ready, 1'b0);
            tick();
            check_bit($sformatf("bp stall%0d o_valid", c), o_valid, 1'b1);
            check_word($sformatf("bp stall%0d o_data", c), o_data, D1);
        end
        o_ready = 1'b1;
        #1;
        check_bit("bp release i_ready", i_ready, 1'b1);
        tick();
        check_word("bp beat2 data", o_data, D2);
        check_bit("bp beat2 end", o_end, 1'b0);
        drive(1'b1, 1'b0, 1'b1, D0, 3'd0, 16'd0);
        tick();
        check_word("bp beat3 data", o_data, D0);
        check_bit("bp beat3 end", o_end, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 64'h0, 3'd0, 16'd0);
        tick();
        check_bit("bp drained o_valid", o_valid, 1'b0);

        // Asynchronous reset in the middle of a streaming burst, then a fresh offset burst.
        drive(1'b1, 1'b1, 1'b0, D0, 3'd0, 16'd24);
        tick();
        drive(1'b1, 1'b0, 1'b0, D1, 3'd0, 16'd0);
        tick();
        check_bit("pre-reset o_valid", o_valid, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 64'h0, 3'd0, 16'd0);
        #1 rst = 1'b1;
        #1;
        check_bit("midrst o_valid", o_valid, 1'b0);
        check_bit("midrst o_idle", o_idle, 1'b1);
        check_bit("midrst i_ready", i_ready, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, D0, 3'd1, 16'd8);
        tick();
        check_bit("post-rst prime o_valid", o_valid, 1'b0);
        drive(1'b1, 1'b0, 1'b1, D1, 3'd0, 16'd0);
        tick();
        check_bit("post-rst o_valid", o_valid, 1'b1);
        check_bit("post-rst o_start", o_start, 1'b1);
        check_bit("post-rst o_end", o_end, 1'b1);
        check_word("post-rst o_data", o_data, 64'h0807060504030201);
        drive(1'b0, 1'b0, 1'b0, 64'h0, 3'd0, 16'd0);
        tick();
        check_bit("post-rst done o_valid", o_valid, 1'b0);
        check_bit("post-rst done o_idle", o_idle, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
